sip_slice_feeder: RTL and testbench
===================================

SIP_SLICE_FEEDER -- requirements
Module: sip_slice_feeder

Interface
REQ-001 SHALL have parameter N_DOT, default 32, number of dot lanes.
REQ-002 SHALL have parameter BITS_PARALLEL, default 1, bits per issued slice.
REQ-003 SHALL have parameter MAX_PREC, default 8, maximum operand precision in bits, a multiple of BITS_PARALLEL.
REQ-004 SHALL have port i_CLK, input, 1, the single clock (rising edge).
REQ-005 SHALL have port i_RST, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have ports i_Valid input 1 and o_Ready output 1: load handshake.
REQ-007 SHALL have ports i_ActVec and i_WeightVec, input, N_DOT*MAX_PREC: element k at [MAX_PREC*k +: MAX_PREC], LSB-aligned.
REQ-008 SHALL have ports i_PrecA and i_PrecW, input, 4: operand precision in bits.
REQ-009 SHALL have ports i_SignedA and i_SignedW, input, 1: operand is two's complement.
REQ-010 SHALL have ports o_Valid output 1 and i_Ready input 1: issue handshake.
REQ-011 SHALL have ports o_Act and o_Weight, output, N_DOT*BITS_PARALLEL: lane k slice at [BITS_PARALLEL*k +: BITS_PARALLEL].
REQ-012 SHALL have ports o_SignI and o_SignW, output, 1: the issued slice is the signed MSB slice.
REQ-013 SHALL have port o_Shift, output, 5: weight of issued pair, a*BITS_PARALLEL + w*BITS_PARALLEL.
REQ-014 SHALL have port o_Last, output, 1: the final pair of the current vector.

Function
REQ-015 SHALL use FSM states IDLE and ISSUE; o_Ready = 1 only in IDLE.
REQ-016 SHALL, on i_Valid & o_Ready, register both vectors, precisions and sign flags, and enter ISSUE; first o_Valid is the next cycle.
REQ-017 SHALL compute slice counts SA = PrecA/BITS_PARALLEL and SW = PrecW/BITS_PARALLEL; precision 0 or above MAX_PREC SHALL be treated as MAX_PREC.
REQ-018 SHALL issue all SA*SW pairs (a,w), LSB first, with a incrementing fastest and w outer.
REQ-019 SHALL drive o_Act with slice a and o_Weight with slice w of every lane.
REQ-020 SHALL assert o_SignI iff SignedA and a = SA-1, and o_SignW iff SignedW and w = SW-1.
REQ-021 SHALL advance to the next pair only on o_Valid & i_Ready; with i_Ready low, all outputs SHALL hold stable.
REQ-022 SHALL assert o_Last with pair (SA-1, SW-1); its handshake SHALL return to IDLE and drop o_Valid the next cycle, leaving a one-cycle bubble before the next load.
REQ-023 SHALL make all outputs registered, except o_Ready, which is decoded from the state register.
REQ-024 SHALL ignore i_Valid while in ISSUE, and SHALL ignore input vectors when no load handshake occurs.
REQ-025 SHALL give precision 1-bit-per-slice operands (SA = SW = 1) exactly one pair, with o_Last set.

Reset
REQ-026 SHALL, with i_RST high at a rising edge, enter IDLE and clear o_Valid, o_Act, o_Weight, o_SignI, o_SignW, o_Shift, o_Last and the counters to 0.
REQ-027 SHALL let reset asserted during ISSUE abort the vector with no further pairs; o_Ready SHALL be 1 on the cycle after reset deasserts.
REQ-028 SHALL give reset priority over a simultaneous load or issue handshake.

Configuration
REQ-029 SHALL, with macro SIP_FEED_ZSKIP_EN defined, skip any non-last pair whose N_DOT activation slices are all zero, with no cycle spent on it.
REQ-030 SHALL never skip the last pair, so o_Last is always issued; o_Shift, o_SignI and o_SignW of the issued pairs SHALL be unchanged by skipping.
REQ-031 SHALL, without SIP_FEED_ZSKIP_EN, issue exactly SA*SW pairs and contain no zero-detect logic.

Verification
REQ-032 Bench SHALL cover: PrecA=PrecW=2, unsigned, lane0 act=2'b10 wt=2'b11, i_Ready=1 -> 4 pairs, o_Shift 0,1,1,2, lane0 act bits 0,1,0,1, o_Last only on the 4th, o_Ready back 2 cycles after.
REQ-033 Bench SHALL cover: PrecA=4, SignedA=1, PrecW=1, SignedW=0 -> 4 pairs, o_SignI only on a=3, o_SignW never set.
REQ-034 Bench SHALL cover: i_Ready low 3 cycles during pair 2 -> outputs frozen, no pair lost or duplicated.
REQ-035 Bench SHALL cover: i_RST pulse during pair 3 of 16 -> o_Valid=0 next cycle, o_Ready=1, a new load issues from pair (0,0).
REQ-036 Bench SHALL cover: i_PrecA=0 -> 8 activation slices issued per weight slice.
REQ-037 Bench SHALL cover: with SIP_FEED_ZSKIP_EN, PrecA=4, PrecW=1, all acts 4'b1000 -> only the a=3 pair issued, o_Shift=3, o_Last=1; without the macro -> 4 pairs.

Source files
------------

// File: rtl/sip_slice_feeder.sv
// sip_slice_feeder: bit-slice issue sequencer for a serial-in-parallel dot engine.
// Accepts one activation vector and one weight vector per load handshake, then
// issues every (activation slice, weight slice) pair, LSB first, with the
// activation slice index incrementing fastest.
//
// Optional feature: define SIP_FEED_ZSKIP_EN to skip non-last pairs whose
// activation slices are zero on every lane, without spending a cycle on them.
//
// Ports:
//   i_CLK, i_RST           clock, synchronous active-high reset
//   i_Valid / o_Ready      load handshake (o_Ready decoded from state)
//   i_ActVec, i_WeightVec  N_DOT elements of MAX_PREC bits, LSB-aligned
//   i_PrecA, i_PrecW       operand precision in bits (0 or >MAX_PREC = MAX_PREC)
//   i_SignedA, i_SignedW   operands are two's complement
//   o_Valid / i_Ready      issue handshake
//   o_Act, o_Weight        per-lane slice of the issued pair
//   o_SignI, o_SignW       issued slice is the signed MSB slice
//   o_Shift                bit weight of the issued pair
//   o_Last                 final pair of the current vector
module sip_slice_feeder #(
    parameter int unsigned N_DOT         = 32,
    parameter int unsigned BITS_PARALLEL = 1,
    parameter int unsigned MAX_PREC      = 8
) (
    input  logic                               i_CLK,
    input  logic                               i_RST,
    input  logic                               i_Valid,
    output logic                               o_Ready,
    input  logic [N_DOT*MAX_PREC-1:0]          i_ActVec,
    input  logic [N_DOT*MAX_PREC-1:0]          i_WeightVec,
    input  logic [3:0]                         i_PrecA,
    input  logic [3:0]                         i_PrecW,
    input  logic                               i_SignedA,
    input  logic                               i_SignedW,
    output logic                               o_Valid,
    input  logic                               i_Ready,
    output logic [N_DOT*BITS_PARALLEL-1:0]     o_Act,
    output logic [N_DOT*BITS_PARALLEL-1:0]     o_Weight,
    output logic                               o_SignI,
    output logic                               o_SignW,
    output logic [4:0]                         o_Shift,
    output logic                               o_Last
);

    localparam int unsigned MAX_S = MAX_PREC / BITS_PARALLEL;
    localparam int unsigned CW    = $clog2(MAX_S + 1);
    localparam int unsigned VW    = N_DOT * MAX_PREC;
    localparam int unsigned OW    = N_DOT * BITS_PARALLEL;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state_q;
    logic [VW-1:0]   act_q;
    logic [VW-1:0]   wt_q;
    logic [CW-1:0]   sa_q;
    logic [CW-1:0]   sw_q;
    logic [CW-1:0]   a_q;
    logic [CW-1:0]   w_q;
    logic            signed_a_q;
    logic            signed_w_q;

    logic            load;
    logic            adv;
    logic [VW-1:0]   src_act;
    logic [VW-1:0]   src_wt;
    logic [CW-1:0]   src_sa;
    logic [CW-1:0]   src_sw;
    logic            src_sga;
    logic            src_sgw;
    logic [CW-1:0]   start_a;
    logic [CW-1:0]   start_w;
    logic [CW-1:0]   nxt_a;
    logic [CW-1:0]   nxt_w;
    logic [OW-1:0]   nxt_act;
    logic [OW-1:0]   nxt_wt;
    logic            nxt_sign_i;
    logic            nxt_sign_w;
    logic            nxt_last;
    logic [4:0]      nxt_shift;

    // Number of slices for a requested precision, out-of-range clamped to MAX_PREC.
    function automatic logic [CW-1:0] slice_count(input logic [3:0] prec);
        int unsigned bits;
        bits = 32'(prec);
        if (bits == 0 || bits > MAX_PREC) bits = MAX_PREC;
        bits = bits / BITS_PARALLEL;
        if (bits == 0) bits = 1;
        return CW'(bits);
    endfunction

    // Gather slice idx of every lane into one issue word.
    function automatic logic [OW-1:0] get_slice(input logic [VW-1:0] vec,
                                                input logic [CW-1:0] idx);
        logic [OW-1:0] s;
        s = '0;
        for (int k = 0; k < int'(N_DOT); k++) begin
            s[BITS_PARALLEL*k +: BITS_PARALLEL] =
                vec[MAX_PREC*k + BITS_PARALLEL*int'(idx) +: BITS_PARALLEL];
        end
        return s;
    endfunction

    assign o_Ready = (state_q == IDLE);

`ifdef SIP_FEED_ZSKIP_EN
    logic [MAX_S-1:0] nz;
    logic             hit;
    logic             any_nz;
    logic             last_row;
    logic [CW-1:0]    first_a;
`endif

    // Select the source operands and the next pair to present.
    always_comb begin
        load    = (state_q == IDLE) && i_Valid;
        adv     = (state_q == ISSUE) && o_Valid && i_Ready && !o_Last;
        src_act = load ? i_ActVec    : act_q;
        src_wt  = load ? i_WeightVec : wt_q;
        src_sa  = load ? slice_count(i_PrecA) : sa_q;
        src_sw  = load ? slice_count(i_PrecW) : sw_q;
        src_sga = load ? i_SignedA : signed_a_q;
        src_sgw = load ? i_SignedW : signed_w_q;

        // Sequential successor of the current pair (or (0,0) on load).
        if (load) begin
            start_a = '0;
            start_w = '0;
        end else if (CW'(a_q + CW'(1)) < sa_q) begin
            start_a = CW'(a_q + CW'(1));
            start_w = w_q;
        end else begin
            start_a = '0;
            start_w = CW'(w_q + CW'(1));
        end

`ifdef SIP_FEED_ZSKIP_EN
        for (int i = 0; i < int'(MAX_S); i++) begin
            nz[i] = |get_slice(src_act, CW'(i));
        end
        // The final pair of the last weight row is never skipped.
        last_row = (start_w == CW'(src_sw - CW'(1)));
        hit      = 1'b0;
        any_nz   = 1'b0;
        first_a  = '0;
        nxt_a    = CW'(src_sa - CW'(1));
        nxt_w    = CW'(src_sw - CW'(1));
        for (int i = int'(MAX_S) - 1; i >= 0; i--) begin
            if (CW'(i) >= start_a && CW'(i) < src_sa &&
                (nz[i] || (last_row && CW'(i) == CW'(src_sa - CW'(1))))) begin
                hit   = 1'b1;
                nxt_a = CW'(i);
                nxt_w = start_w;
            end
            if (CW'(i) < src_sa && nz[i]) begin
                any_nz  = 1'b1;
                first_a = CW'(i);
            end
        end
        // Zero pattern depends only on a, so an empty next row means every
        // remaining non-last row is empty: jump straight to the last pair.
        if (!hit && any_nz) begin
            nxt_a = first_a;
            nxt_w = CW'(start_w + CW'(1));
        end
`else
        nxt_a = start_a;
        nxt_w = start_w;
`endif

        nxt_act    = get_slice(src_act, nxt_a);
        nxt_wt     = get_slice(src_wt, nxt_w);
        nxt_sign_i = src_sga && (nxt_a == CW'(src_sa - CW'(1)));
        nxt_sign_w = src_sgw && (nxt_w == CW'(src_sw - CW'(1)));
        nxt_last   = (nxt_a == CW'(src_sa - CW'(1))) && (nxt_w == CW'(src_sw - CW'(1)));
        nxt_shift  = 5'(BITS_PARALLEL * (32'(nxt_a) + 32'(nxt_w)));
    end

    // State register, operand capture and registered issue outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= IDLE;
            act_q      <= '0;
            wt_q       <= '0;
            sa_q       <= '0;
            sw_q       <= '0;
            a_q        <= '0;
            w_q        <= '0;
            signed_a_q <= 1'b0;
            signed_w_q <= 1'b0;
            o_Valid    <= 1'b0;
            o_Act      <= '0;
            o_Weight   <= '0;
            o_SignI    <= 1'b0;
            o_SignW    <= 1'b0;
            o_Shift    <= '0;
            o_Last     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        act_q      <= i_ActVec;
                        wt_q       <= i_WeightVec;
                        sa_q       <= src_sa;
                        sw_q       <= src_sw;
                        signed_a_q <= i_SignedA;
                        signed_w_q <= i_SignedW;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (o_Valid && i_Ready && o_Last) begin
                        state_q <= IDLE;
                        o_Valid <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load || adv) begin
                o_Valid  <= 1'b1;
                a_q      <= nxt_a;
                w_q      <= nxt_w;
                o_Act    <= nxt_act;
                o_Weight <= nxt_wt;
                o_SignI  <= nxt_sign_i;
                o_SignW  <= nxt_sign_w;
                o_Shift  <= nxt_shift;
                o_Last   <= nxt_last;
            end
        end
    end

endmodule

// File: tb/tb_sip_slice_feeder.sv
// Scoreboard bench for sip_slice_feeder with default parameters
// (N_DOT=32, BITS_PARALLEL=1, MAX_PREC=8).
module tb_sip_slice_feeder;

    logic         clk;
    logic         rst;
    logic         i_Valid;
    logic         o_Ready;
    logic [255:0] i_ActVec;
    logic [255:0] i_WeightVec;
    logic [3:0]   i_PrecA;
    logic [3:0]   i_PrecW;
    logic         i_SignedA;
    logic         i_SignedW;
    logic         o_Valid;
    logic         i_Ready;
    logic [31:0]  o_Act;
    logic [31:0]  o_Weight;
    logic         o_SignI;
    logic         o_SignW;
    logic [4:0]   o_Shift;
    logic         o_Last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] act;
        logic [31:0] wt;
        logic [4:0]  shift;
        logic        si;
        logic        sw;
        logic        last;
    } exp_t;

    exp_t exp_q[$];

    sip_slice_feeder dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_Valid    (i_Valid),
        .o_Ready    (o_Ready),
        .i_ActVec   (i_ActVec),
        .i_WeightVec(i_WeightVec),
        .i_PrecA    (i_PrecA),
        .i_PrecW    (i_PrecW),
        .i_SignedA  (i_SignedA),
        .i_SignedW  (i_SignedW),
        .o_Valid    (o_Valid),
        .i_Ready    (i_Ready),
        .o_Act      (o_Act),
        .o_Weight   (o_Weight),
        .o_SignI    (o_SignI),
        .o_SignW    (o_SignW),
        .o_Shift    (o_Shift),
        .o_Last     (o_Last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [31:0] a, input logic [31:0] w,
                                 input logic [4:0] sh, input logic si,
                                 input logic sw, input logic lst);
        exp_t e;
        e.act = a; e.wt = w; e.shift = sh; e.si = si; e.sw = sw; e.last = lst;
        exp_q.push_back(e);
    endfunction

    // Monitor: every presented pair must match the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (o_Valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair: got shift %0d act 0x%0h with no pair expected", o_Shift, o_Act);
            end else begin
                chk("act",    o_Act,           exp_q[0].act);
                chk("weight", o_Weight,        exp_q[0].wt);
                chk("shift",  32'(o_Shift),    32'(exp_q[0].shift));
                chk("sign_i", 32'(o_SignI),    32'(exp_q[0].si));
                chk("sign_w", 32'(o_SignW),    32'(exp_q[0].sw));
                chk("last",   32'(o_Last),     32'(exp_q[0].last));
                if (i_Ready && !rst) void'(exp_q.pop_front());
            end
        end
    end

    task automatic load(input logic [255:0] av, input logic [255:0] wv,
                        input logic [3:0] pa, input logic [3:0] pw,
                        input logic sa, input logic sw);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!o_Ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_load", 32'(o_Ready), 32'd1);
        i_ActVec = av; i_WeightVec = wv;
        i_PrecA = pa; i_PrecW = pw; i_SignedA = sa; i_SignedW = sw;
        i_Valid = 1'b1;
        @(posedge clk); #1;
        i_Valid = 1'b0;
        // Inputs outside a load handshake must not matter.
        i_ActVec = '1; i_WeightVec = '1;
        i_PrecA = 4'd3; i_PrecW = 4'd3; i_SignedA = 1'b1; i_SignedW = 1'b1;
        chk("valid_after_load", 32'(o_Valid), 32'd1);
        chk("ready_in_issue",   32'(o_Ready), 32'd0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || o_Valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || o_Valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d pairs outstanding, o_Valid %0b", name, exp_q.size(), o_Valid);
            exp_q.delete();
        end
        chk({name, "_ready_after"}, 32'(o_Ready), 32'd1);
    endtask

    initial begin
        logic [7:0] av8;
        logic [1:0] wv2;
        logic [255:0] all_act;
        logic [255:0] all_wt;

        rst = 1'b1; i_Valid = 1'b0; i_Ready = 1'b1;
        i_ActVec = '0; i_WeightVec = '0;
        i_PrecA = '0; i_PrecW = '0; i_SignedA = 1'b0; i_SignedW = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(o_Ready), 32'd1);
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_act",   o_Act,        32'd0);
        chk("rst_shift", 32'(o_Shift), 32'd0);
        chk("rst_last",  32'(o_Last),  32'd0);

        // 2x2 unsigned: act=10, wt=11.
        push(32'd0, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        push(32'd1, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        push(32'd0, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        push(32'd1, 32'd1, 5'd2, 1'b0, 1'b0, 1'b1);
        load(256'h2, 256'h3, 4'd2, 4'd2, 1'b0, 1'b0);
        wait_done("p2x2");

        // 4-bit signed activations, 1-bit unsigned weight: act=1010, wt=1.
        push(32'd0, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        push(32'd1, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        push(32'd0, 32'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        push(32'd1, 32'd1, 5'd3, 1'b1, 1'b0, 1'b1);
        load(256'ha, 256'h1, 4'd4, 4'd1, 1'b1, 1'b0);
        wait_done("signed");

        // Back-pressure for 3 cycles while pair 2 is presented: act=01, wt=10.
        push(32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        push(32'd0, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        push(32'd1, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        push(32'd0, 32'd1, 5'd2, 1'b0, 1'b0, 1'b1);
        load(256'h1, 256'h2, 4'd2, 4'd2, 1'b0, 1'b0);
        @(posedge clk); #1 i_Ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_Ready = 1'b1;
        wait_done("stall");

        // Reset while pair 3 of 16 is presented: act=0110, wt=1001.
        push(32'd0, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        push(32'd1, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        push(32'd1, 32'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        load(256'h6, 256'h9, 4'd4, 4'd4, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("abort_valid", 32'(o_Valid), 32'd0);
        chk("abort_ready", 32'(o_Ready), 32'd1);
        @(negedge clk);
        chk("abort_valid2", 32'(o_Valid), 32'd0);
        chk("abort_ready2", 32'(o_Ready), 32'd1);
        push(32'd0, 32'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        push(32'd1, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        push(32'd0, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        push(32'd1, 32'd1, 5'd2, 1'b0, 1'b0, 1'b1);
        load(256'h2, 256'h3, 4'd2, 4'd2, 1'b0, 1'b0);
        wait_done("reload");

        // Single-slice operands: exactly one pair carrying o_Last.
        push(32'd1, 32'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        load(256'h1, 256'h0, 4'd1, 4'd1, 1'b1, 1'b1);
        wait_done("single");

        // Precision 0 means 8 activation slices per weight slice (2 weight slices).
        av8 = 8'b1100_0101;
        wv2 = 2'b10;
        for (int w = 0; w < 2; w++) begin
            for (int a = 0; a < 8; a++) begin
                push(32'(av8[a]), 32'(wv2[w]), 5'(a + w), 1'b0, 1'b0, (a == 7) && (w == 1));
            end
        end
        load(256'(av8), 256'(wv2), 4'd0, 4'd2, 1'b0, 1'b0);
        wait_done("prec0");

        // Every lane act=1000, wt=1.
        all_act = '0;
        all_wt  = '0;
        for (int k = 0; k < 32; k++) begin
            all_act[8*k +: 8] = 8'h08;
            all_wt[8*k +: 8]  = 8'h01;
        end
`ifdef SIP_FEED_ZSKIP_EN
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b0, 1'b1);
`else
        push(32'd0, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b0);
        push(32'd0, 32'hFFFF_FFFF, 5'd1, 1'b0, 1'b0, 1'b0);
        push(32'd0, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b0, 1'b0);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b0, 1'b1);
`endif
        load(all_act, all_wt, 4'd4, 4'd1, 1'b0, 1'b0);
        wait_done("zskip");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end

endmodule
